// File: rtl/char_feature_extract.sv
// char_feature_extract: splits the first plate character's bounding box into a
// 5-column x 8-row grid, counts foreground/total pixels per cell, thresholds each
// cell and emits a 40-bit feature word (bit = row*5 + col).
// Optional build macro: CHAR_FEAT_INVERT_EN adds the feat_invert input, which
// inverts the binarized pixel for light-on-dark plates.
module char_feature_extract #(
  parameter int unsigned COORD_W = 11,
  parameter int unsigned CNT_W   = 12,
  parameter int unsigned THRESH  = 8
) (
  input  logic               pixelclk,
  input  logic               reset_n,
  input  logic               i_vs,
  input  logic               i_de,
  input  logic               i_bin,
  input  logic [COORD_W-1:0] box_left,
  input  logic [COORD_W-1:0] box_right,
  input  logic [COORD_W-1:0] box_top,
  input  logic [COORD_W-1:0] box_bottom,
`ifdef CHAR_FEAT_INVERT_EN
  input  logic               feat_invert,
`endif
  output logic [39:0]        char_feat,
  output logic               feat_valid,
  output logic               box_err
);

  localparam int unsigned NCELL  = 40;
  localparam int unsigned SPAN_W = COORD_W + 1;  // W/H range up to 2^COORD_W
  localparam int unsigned ACC_W  = COORD_W + 2;  // accumulator plus step headroom
  localparam int unsigned PROD_W = CNT_W + 5;    // room for fg*16 and total*THRESH
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCUM,
    ST_EVAL,
    ST_DONE
  } state_t;

  state_t             state_q;
  logic               vs_q;
  logic               de_q;
  logic [COORD_W-1:0] x_q;
  logic [COORD_W-1:0] y_q;
  logic [COORD_W-1:0] left_q;
  logic [COORD_W-1:0] right_q;
  logic [COORD_W-1:0] top_q;
  logic [COORD_W-1:0] bottom_q;
  logic [SPAN_W-1:0]  w_q;
  logic [SPAN_W-1:0]  h_q;
  logic [2:0]         col_q;
  logic [2:0]         row_q;
  logic [ACC_W-1:0]   cacc_q;
  logic [ACC_W-1:0]   racc_q;
  logic [CNT_W-1:0]   fg_q  [NCELL];
  logic [CNT_W-1:0]   tot_q [NCELL];
  logic [5:0]         eval_idx_q;
  logic [39:0]        shadow_q;
  logic [39:0]        char_feat_q;
  logic               feat_valid_q;
  logic               box_err_q;
`ifdef CHAR_FEAT_INVERT_EN
  logic               inv_q;
`endif

  logic               vs_rise;
  logic               de_fall;
  logic               frame_start;
  logic [SPAN_W-1:0]  w_d;
  logic [SPAN_W-1:0]  h_d;
  logic               box_bad;
  logic               pix_in;
  logic               line_in;
  logic               pix_fg;
  logic [5:0]         cell_idx;
  logic [ACC_W-1:0]   cacc_sum;
  logic [ACC_W-1:0]   racc_sum;
  logic [PROD_W-1:0]  fg_scaled;
  logic [PROD_W-1:0]  tot_scaled;
  logic               cell_bit;

  // Event decode, box geometry and the shared per-cell threshold compare.
  always_comb begin
    vs_rise     = i_vs & ~vs_q;
    de_fall     = ~i_de & de_q;
    // A frame sync arriving during EVAL/DONE is dropped; that frame is skipped.
    frame_start = vs_rise && (state_q == ST_IDLE || state_q == ST_ACCUM);

    w_d     = {1'b0, box_right} - {1'b0, box_left} + SPAN_W'(1);
    h_d     = {1'b0, box_bottom} - {1'b0, box_top} + SPAN_W'(1);
    box_bad = (box_right < box_left) || (box_bottom < box_top) ||
              (w_d < SPAN_W'(5)) || (h_d < SPAN_W'(8));

    pix_in  = (state_q == ST_ACCUM) && i_de &&
              (x_q >= left_q) && (x_q <= right_q) &&
              (y_q >= top_q) && (y_q <= bottom_q);
    line_in = (state_q == ST_ACCUM) && de_fall &&
              (y_q >= top_q) && (y_q <= bottom_q);

`ifdef CHAR_FEAT_INVERT_EN
    pix_fg = i_bin ^ inv_q;
`else
    pix_fg = i_bin;
`endif

    cell_idx = 6'(row_q) * 6'd5 + 6'(col_q);
    cacc_sum = cacc_q + ACC_W'(5);
    racc_sum = racc_q + ACC_W'(8);

    fg_scaled  = PROD_W'(fg_q[eval_idx_q]) << 4;
    tot_scaled = PROD_W'(tot_q[eval_idx_q]) * PROD_W'(THRESH);
    cell_bit   = (tot_q[eval_idx_q] != '0) && (fg_scaled >= tot_scaled);
  end

  // Previous-cycle copies of the sync strobes for edge detection.
  always_ff @(posedge pixelclk or negedge reset_n) begin
    if (!reset_n) begin
      vs_q <= 1'b0;
      de_q <= 1'b0;
    end else begin
      vs_q <= i_vs;
      de_q <= i_de;
    end
  end

  // Raster position: x counts active pixels per line, y counts line ends per frame.
  always_ff @(posedge pixelclk or negedge reset_n) begin
    if (!reset_n) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      if (de_fall) begin
        x_q <= '0;
      end else if (i_de) begin
        x_q <= x_q + COORD_W'(1);
      end
      if (vs_rise) begin
        y_q <= '0;
      end else if (de_fall) begin
        y_q <= y_q + COORD_W'(1);
      end
    end
  end

  // Frame sequencing: box latch, accumulate, serial evaluation and result update.
  always_ff @(posedge pixelclk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      left_q       <= '0;
      right_q      <= '0;
      top_q        <= '0;
      bottom_q     <= '0;
      w_q          <= '0;
      h_q          <= '0;
      eval_idx_q   <= '0;
      shadow_q     <= '0;
      char_feat_q  <= '0;
      feat_valid_q <= 1'b0;
      box_err_q    <= 1'b0;
`ifdef CHAR_FEAT_INVERT_EN
      inv_q        <= 1'b0;
`endif
    end else begin
      feat_valid_q <= 1'b0;
      if (frame_start) begin
        left_q   <= box_left;
        right_q  <= box_right;
        top_q    <= box_top;
        bottom_q <= box_bottom;
        w_q      <= w_d;
        h_q      <= h_d;
`ifdef CHAR_FEAT_INVERT_EN
        inv_q    <= feat_invert;
`endif
        if (box_bad) begin
          box_err_q <= 1'b1;
          state_q   <= ST_IDLE;
        end else begin
          box_err_q <= 1'b0;
          state_q   <= ST_ACCUM;
        end
      end else begin
        unique case (state_q)
          ST_ACCUM: begin
            if (line_in && (y_q == bottom_q)) begin
              state_q    <= ST_EVAL;
              eval_idx_q <= '0;
            end
          end
          ST_EVAL: begin
            shadow_q[eval_idx_q] <= cell_bit;
            if (eval_idx_q == 6'd39) begin
              state_q <= ST_DONE;
            end else begin
              eval_idx_q <= eval_idx_q + 6'd1;
            end
          end
          ST_DONE: begin
            char_feat_q  <= shadow_q;
            feat_valid_q <= 1'b1;
            state_q      <= ST_IDLE;
          end
          default: begin
          end
        endcase
      end
    end
  end

  // Grid stepping: column/row advance by error accumulation instead of dividing by W/H.
  always_ff @(posedge pixelclk or negedge reset_n) begin
    if (!reset_n) begin
      col_q  <= '0;
      row_q  <= '0;
      cacc_q <= '0;
      racc_q <= '0;
    end else if (frame_start) begin
      col_q  <= '0;
      row_q  <= '0;
      cacc_q <= '0;
      racc_q <= '0;
    end else begin
      if (pix_in) begin
        if (cacc_sum >= ACC_W'(w_q)) begin
          cacc_q <= cacc_sum - ACC_W'(w_q);
          if (col_q != 3'd4) begin
            col_q <= col_q + 3'd1;
          end
        end else begin
          cacc_q <= cacc_sum;
        end
      end else if (de_fall) begin
        cacc_q <= '0;
        col_q  <= '0;
      end
      if (line_in) begin
        if (racc_sum >= ACC_W'(h_q)) begin
          racc_q <= racc_sum - ACC_W'(h_q);
          if (row_q != 3'd7) begin
            row_q <= row_q + 3'd1;
          end
        end else begin
          racc_q <= racc_sum;
        end
      end
    end
  end

  // Per-cell saturating foreground and total pixel counters.
  always_ff @(posedge pixelclk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < NCELL; i++) begin
        fg_q[i]  <= '0;
        tot_q[i] <= '0;
      end
    end else if (frame_start && !box_bad) begin
      for (int unsigned i = 0; i < NCELL; i++) begin
        fg_q[i]  <= '0;
        tot_q[i] <= '0;
      end
    end else if (pix_in) begin
      if (tot_q[cell_idx] != CNT_MAX) begin
        tot_q[cell_idx] <= tot_q[cell_idx] + CNT_W'(1);
      end
      if (pix_fg && (fg_q[cell_idx] != CNT_MAX)) begin
        fg_q[cell_idx] <= fg_q[cell_idx] + CNT_W'(1);
      end
    end
  end

  assign char_feat  = char_feat_q;
  assign feat_valid = feat_valid_q;
  assign box_err    = box_err_q;

endmodule

// File: tb/tb_char_feature_extract.sv
// tb_char_feature_extract: drives raster frames from a pixel image and checks the
// feature word, pulse count, latency and box error flag against a reference model
// that maps each in-box pixel to its grid cell by direct proportional arithmetic.
module tb_char_feature_extract;

  localparam int COORD_W = 11;
  localparam int LINE_W  = 40;
  localparam int NLINES  = 50;
  localparam int HBLANK  = 4;

  logic               clk   = 1'b0;
  logic               rst_n = 1'b0;
  logic               vs    = 1'b0;
  logic               de    = 1'b0;
  logic               bin   = 1'b0;
  logic [COORD_W-1:0] bl    = '0;
  logic [COORD_W-1:0] br    = '0;
  logic [COORD_W-1:0] bt    = '0;
  logic [COORD_W-1:0] bb    = '0;
  logic [39:0]        feat;
  logic               fvalid;
  logic               berr;
`ifdef CHAR_FEAT_INVERT_EN
  logic               finv  = 1'b0;
`endif

  bit          img [NLINES][LINE_W];
  int          cyc      = 0;
  int          drop_cyc = 0;
  int          fv_cnt   = 0;
  int          fv_cyc   = 0;
  logic [39:0] fv_data  = '0;
  int          n_vec    = 0;
  int          n_err    = 0;

  char_feature_extract #(
    .COORD_W(COORD_W),
    .CNT_W  (12),
    .THRESH (8)
  ) dut (
    .pixelclk  (clk),
    .reset_n   (rst_n),
    .i_vs      (vs),
    .i_de      (de),
    .i_bin     (bin),
    .box_left  (bl),
    .box_right (br),
    .box_top   (bt),
    .box_bottom(bb),
`ifdef CHAR_FEAT_INVERT_EN
    .feat_invert(finv),
`endif
    .char_feat (feat),
    .feat_valid(fvalid),
    .box_err   (berr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (fvalid === 1'b1) begin
      fv_cnt  = fv_cnt + 1;
      fv_cyc  = cyc;
      fv_data = feat;
    end
  end

  initial begin
    #4000000;
    $display("FAIL watchdog: simulation did not finish, observed timeout, expected finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec = n_vec + 1;
    if (got !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: observed %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic fill_const(input bit v);
    for (int y = 0; y < NLINES; y++)
      for (int x = 0; x < LINE_W; x++)
        img[y][x] = v;
  endtask

  task automatic fill_random(input int dens);
    for (int y = 0; y < NLINES; y++)
      for (int x = 0; x < LINE_W; x++)
        img[y][x] = ($urandom_range(0, 99) < dens);
  endtask

  // Reference: pixel offset d in a span of S cells-worth maps to floor(d*N/S).
  function automatic logic [39:0] model_feat(input int l, input int r, input int t, input int b);
    int          fg  [40];
    int          tot [40];
    logic [39:0] f;
    int          w;
    int          h;
    f = '0;
    w = r - l + 1;
    h = b - t + 1;
    for (int i = 0; i < 40; i++) begin
      fg[i]  = 0;
      tot[i] = 0;
    end
    for (int y = t; y <= b && y < NLINES; y++) begin
      for (int x = l; x <= r && x < LINE_W; x++) begin
        int c;
        int rr;
        c  = (5 * (x - l)) / w;
        rr = (8 * (y - t)) / h;
        if (c > 4) c = 4;
        if (rr > 7) rr = 7;
        tot[rr * 5 + c]++;
        if (img[y][x]) fg[rr * 5 + c]++;
      end
    end
    for (int i = 0; i < 40; i++)
      f[i] = (tot[i] > 0) && (fg[i] * 16 >= tot[i] * 8);
    return f;
  endfunction

  // Called and returns on a falling clock edge; stops before line abort_line.
  task automatic run_frame(input int l, input int r, input int t, input int b,
                           input int abort_line, input int tail);
    bl = COORD_W'(l);
    br = COORD_W'(r);
    bt = COORD_W'(t);
    bb = COORD_W'(b);
    vs = 1'b1;
    repeat (2) @(negedge clk);
    vs = 1'b0;
    repeat (3) @(negedge clk);
    for (int y = 0; y < NLINES; y++) begin
      if (y == abort_line) return;
      for (int x = 0; x < LINE_W; x++) begin
        de  = 1'b1;
        bin = img[y][x];
        @(negedge clk);
      end
      de  = 1'b0;
      bin = 1'b0;
      if (y == b) drop_cyc = cyc;
      repeat (HBLANK) @(negedge clk);
    end
    repeat (tail) @(negedge clk);
  endtask

  task automatic check_frame(input string tag, input int c0, input int exp_pulses,
                             input logic exp_err, input logic [39:0] exp_feat);
    chk({tag, "_pulses"}, 64'(fv_cnt - c0), 64'(exp_pulses));
    chk({tag, "_boxerr"}, 64'(berr), 64'(exp_err));
    if (exp_pulses > 0) begin
      chk({tag, "_feat"}, 64'(fv_data), 64'(exp_feat));
      chk({tag, "_latency"}, 64'(fv_cyc - drop_cyc - 1), 64'd41);
      chk({tag, "_hold"}, 64'(feat), 64'(exp_feat));
    end
  endtask

  initial begin
    int c0;
    int d1;
    int l;
    int r;
    int t;
    int b;
    logic [39:0] e;

    repeat (3) @(negedge clk);
    chk("rst_feat", 64'(feat), 64'd0);
    chk("rst_valid", 64'(fvalid), 64'd0);
    chk("rst_boxerr", 64'(berr), 64'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // All foreground in a 20x40 box.
    fill_const(1'b1);
    c0 = fv_cnt;
    run_frame(10, 29, 5, 44, -1, 80);
    check_frame("allfg", c0, 1, 1'b0, 40'hFF_FFFF_FFFF);

    // Foreground only in the leftmost column of cells.
    fill_const(1'b0);
    for (int y = 0; y < NLINES; y++)
      for (int x = 10; x <= 13; x++)
        img[y][x] = 1'b1;
    c0 = fv_cnt;
    run_frame(10, 29, 5, 44, -1, 80);
    check_frame("col0", c0, 1, 1'b0, 40'h08_4210_8421);

    // Threshold boundary in cell (0,0): 10/20 sets the bit, 9/20 does not.
    for (int n = 10; n >= 9; n--) begin
      int k;
      fill_const(1'b0);
      k = 0;
      for (int y = 5; y <= 9; y++)
        for (int x = 10; x <= 13; x++) begin
          if (k < n) img[y][x] = 1'b1;
          k++;
        end
      c0 = fv_cnt;
      run_frame(10, 29, 5, 44, -1, 80);
      check_frame((n == 10) ? "thr10" : "thr9", c0, 1, 1'b0, (n == 10) ? 40'h1 : 40'h0);
    end

    // Too-narrow box, then recovery on a valid box.
    fill_const(1'b1);
    c0 = fv_cnt;
    run_frame(10, 12, 5, 44, -1, 80);
    check_frame("narrow", c0, 0, 1'b1, '0);
    c0 = fv_cnt;
    run_frame(10, 29, 5, 44, -1, 80);
    check_frame("recover", c0, 1, 1'b0, 40'hFF_FFFF_FFFF);

    // Frame sync during accumulation aborts; the following frame completes.
    fill_const(1'b0);
    c0 = fv_cnt;
    run_frame(10, 29, 5, 44, 20, 0);
    fill_const(1'b1);
    run_frame(10, 29, 5, 44, -1, 80);
    check_frame("abort_fg", c0, 1, 1'b0, 40'hFF_FFFF_FFFF);

    fill_random(60);
    c0 = fv_cnt;
    run_frame(10, 29, 5, 44, 20, 0);
    fill_random(50);
    run_frame(10, 29, 5, 44, -1, 80);
    check_frame("abort_rnd", c0, 1, 1'b0, model_feat(10, 29, 5, 44));

    // Reset asserted partway through evaluation discards the result.
    fill_const(1'b1);
    c0 = fv_cnt;
    run_frame(10, 29, 5, 44, 45, 0);
    repeat (drop_cyc + 21 - cyc) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("evalrst_feat", 64'(feat), 64'd0);
    chk("evalrst_valid", 64'(fvalid), 64'd0);
    chk("evalrst_boxerr", 64'(berr), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (100) @(negedge clk);
    chk("evalrst_pulses", 64'(fv_cnt - c0), 64'd0);
    c0 = fv_cnt;
    run_frame(10, 29, 5, 44, -1, 80);
    check_frame("postrst", c0, 1, 1'b0, 40'hFF_FFFF_FFFF);

    // Frame sync during evaluation is ignored and that frame is skipped.
    fill_random(45);
    e  = model_feat(8, 30, 2, 40);
    c0 = fv_cnt;
    run_frame(8, 30, 2, 40, 41, 0);
    d1 = drop_cyc;
    repeat (6) @(negedge clk);
    run_frame(0, 39, 0, 47, -1, 80);
    drop_cyc = d1;
    check_frame("vs_in_eval", c0, 1, 1'b0, e);

    // Randomized boxes and images, including boxes past the active area and bad boxes.
    for (int it = 0; it < 10; it++) begin
      bit bad;
      bad = ($urandom_range(0, 3) == 0);
      l = $urandom_range(0, 20);
      t = $urandom_range(0, 10);
      if (bad) begin
        if ($urandom_range(0, 1) == 1) begin
          r = l + $urandom_range(0, 3);
          b = t + $urandom_range(8, 30);
        end else begin
          r = l + $urandom_range(5, 18);
          b = t + $urandom_range(0, 6);
        end
      end else begin
        r = l + $urandom_range(4, 29);
        b = t + $urandom_range(7, 38);
      end
      fill_random($urandom_range(10, 90));
      e  = model_feat(l, r, t, b);
      c0 = fv_cnt;
      run_frame(l, r, t, b, -1, 80);
      check_frame($sformatf("rnd%0d", it), c0, bad ? 0 : 1, bad, e);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/char_feature_extract.md
Name: char_feature_extract

Overview:
- Upstream stage of the province-abbreviation template matcher.
- Takes a binarized pixel stream plus the bounding box of the first plate character (from the character locator).
- Divides the box into a 5-column x 8-row grid and accumulates, per cell, the foreground and total pixel counts.
- Thresholds each cell into one bit and emits the 40-bit feature word that the matcher scores against its templates.

Parameters:
- COORD_W, 11: width of pixel x/y coordinates and box bounds.
- CNT_W, 12: width of per-cell foreground/total counters; counters saturate at 2^CNT_W-1.
- THRESH, 8: cell fill threshold in sixteenths; bit=1 when fg*16 >= total*THRESH.

Ports:
- pixelclk  in  1  pixel clock
- reset_n  in  1  asynchronous active-low reset
- i_vs  in  1  frame sync, active-high; rising edge marks frame start
- i_de  in  1  active-video data enable
- i_bin  in  1  binarized pixel, 1 = foreground (stroke)
- box_left  in  COORD_W  char box left x, inclusive
- box_right  in  COORD_W  char box right x, inclusive
- box_top  in  COORD_W  char box top y, inclusive
- box_bottom  in  COORD_W  char box bottom y, inclusive
- char_feat  out  40  feature word; bit index = row*5+col, with row 0 = top and col 0 = left
- feat_valid  out  1  one-cycle pulse when char_feat updates
- box_err  out  1  sticky per frame; high when the latched box is too small

Behaviour:
- Clock and reset:
  - One clock, pixelclk. Reset is asynchronous and active-low on reset_n.
  - Reset values: char_feat=0, feat_valid=0, box_err=0, all counters 0, FSM=IDLE.
- Coordinates:
  - Internal x counts pixels with i_de=1 within a line and resets to 0 on the falling edge of i_de.
  - Internal y increments on each i_de falling edge and resets to 0 on the i_vs rising edge.
- Box latching:
  - On the i_vs rising edge, box_* are latched. W=right-left+1, H=bottom-top+1.
  - If W<5 or H<8 (this includes right<left), set box_err=1, go to IDLE, and produce no feat_valid for that frame.
  - Otherwise clear box_err, clear all 80 counters, and enter ACCUM.
- Grid stepping (no dividers, Bresenham style):
  - Column accumulator cacc resets to 0 and col to 0 at the start of each line.
  - For each in-box pixel (left<=x<=right, top<=y<=bottom, i_de=1): count into cell (row,col), then cacc+=5. If cacc>=W, then cacc-=W and col++. col is clamped at 4.
  - Rows use the same scheme: racc+=8 at each in-box line end (i_de falling edge on lines top..bottom). If racc>=H, then racc-=H and row++. row is clamped at 7.
- Counting:
  - total[cell]++ for every in-box pixel.
  - fg[cell]++ when i_bin=1.
  - Both counters saturate at 2^CNT_W-1.
- FSM IDLE -> ACCUM -> EVAL -> DONE -> IDLE:
  - ACCUM -> EVAL on the i_de falling edge of line y==box_bottom.
  - EVAL processes one cell per cycle, index 0..39, using one shared compare fg*16 >= total*THRESH. A cell with total=0 yields bit 0. Bits collect into a shadow register.
  - DONE lasts one cycle: char_feat <= shadow, feat_valid=1.
  - Latency: feat_valid occurs 41 cycles after the ACCUM->EVAL transition.
  - char_feat holds its value until the next DONE.
- Boundaries:
  - i_vs rising edge during ACCUM (frame ended before box_bottom was reached): the current frame is aborted with no feat_valid, and a new frame starts (relatch the box).
  - i_vs rising edge during EVAL or DONE: ignored. That frame is skipped, and the FSM returns to IDLE and waits for the next i_vs.
  - A box that extends beyond the active area: only pixels actually seen are counted. If box_bottom is never reached, the abort rule above applies.
  - reset_n asserted mid-operation: immediate return to reset values. Any partial result is discarded.

Optional Feature:
- Macro CHAR_FEAT_INVERT_EN.
- When defined: adds input port feat_invert (1 bit), sampled on the i_vs rising edge. When the sampled value is 1, i_bin is inverted before counting, so light-on-dark plates produce the same feature polarity as dark-on-light plates.
- When undefined: the port is absent and i_bin is used as-is.

Test Plan:
- Box x=10..29, y=5..44 (cells 4x5=20 px), all pixels i_bin=1 -> feat_valid pulse 41 cycles after the line-44 de fall; char_feat=40'hFF_FFFF_FFFF.
- Same box, fg only at x=10..13 -> char_feat=40'h08_4210_8421 (bits 0,5,...,35).
- THRESH=8, cell(0,0) with exactly 10/20 fg, all other cells empty -> bit0=1, char_feat=40'h1. Repeat with 9/20 fg -> char_feat=40'h0.
- Box x=10..12 (W=3) -> box_err=1 and no feat_valid. The next frame with a valid box -> box_err=0 and a normal result.
- i_vs pulse mid-ACCUM at y=20 -> no feat_valid. A full following frame with all fg -> 40'hFF_FFFF_FFFF.
- reset_n low during EVAL (cycle 20 of 40) -> char_feat=0 and feat_valid=0. After release, a full frame -> correct result with 41-cycle latency.
